// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between the CPU and DMA ports.
// Each access runs SETUP -> STROBE (WAIT cycles) -> HOLD; every output is registered.
module sram_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20,
   parameter int WAIT   = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_data_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              busy
);

   generate
      if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
         $error("sram_arbiter: WAIT must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t     state;
   logic       last_dma;   // port served most recently
   logic       owner_dma;
   logic       acc_we;
   logic [3:0] cnt;
   logic       grant_dma;

   // On a tie the port not served last wins.
   assign grant_dma = dma_req & (~cpu_req | ~last_dma);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         last_dma     <= 1'b1;
         owner_dma    <= 1'b0;
         acc_we       <= 1'b0;
         cnt          <= '0;
         sram_addr    <= '0;
         sram_wdata   <= '0;
         sram_data_oe <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         cpu_gnt      <= 1'b0;
         dma_gnt      <= 1'b0;
         cpu_done     <= 1'b0;
         dma_done     <= 1'b0;
         cpu_rdata    <= '0;
         dma_rdata    <= '0;
         busy         <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         dma_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  state        <= SETUP;
                  owner_dma    <= grant_dma;
                  last_dma     <= grant_dma;
                  acc_we       <= grant_dma ? dma_we : cpu_we;
                  sram_addr    <= grant_dma ? dma_addr : cpu_addr;
                  sram_wdata   <= grant_dma ? dma_wdata : cpu_wdata;
                  sram_data_oe <= grant_dma ? dma_we : cpu_we;
                  sram_ce_n    <= 1'b0;
                  cpu_gnt      <= ~grant_dma;
                  dma_gnt      <= grant_dma;
                  busy         <= 1'b1;
               end
            end
            SETUP: begin
               state     <= STROBE;
               cnt       <= 4'(WAIT - 1);
               sram_oe_n <= acc_we;
               sram_we_n <= ~acc_we;
            end
            STROBE: begin
               if (cnt == 4'd0) begin
                  state     <= HOLD;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  cpu_done  <= ~owner_dma;
                  dma_done  <= owner_dma;
                  if (!acc_we) begin
                     if (owner_dma) dma_rdata <= sram_rdata;
                     else           cpu_rdata <= sram_rdata;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: begin
               state        <= IDLE;
               sram_ce_n    <= 1'b1;
               sram_data_oe <= 1'b0;
               cpu_gnt      <= 1'b0;
               dma_gnt      <= 1'b0;
               busy         <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
